wb_mem_slave: RTL

Pipelined Wishbone responder fronting an on-chip synchronous word RAM; it serves the bexkat1 instruction fetch path and data ports as the slave end of the `if_wb` protocol. Accepts one request per cycle when not stalled and returns exactly one `ack` per accepted request, in order, a fixed `LATENCY` cycles after acceptance. If the master drops `cyc`, all in-flight requests are flushed and no stale `ack` escapes.

---
 rtl/wb_mem_slave_if.sv | 24 ++
 rtl/wb_mem_slave.sv | 66 ++++++
 2 files changed

// File: rtl/wb_mem_slave_if.sv
// Purpose : pipelined Wishbone bus bundle shared by a master and a memory slave.
// Ports   : cyc/stb/we/sel/adr/dat_m driven by the master; dat_s/ack/stall driven by the slave.
// Timing  : no logic here; request and response timing belongs to the endpoints.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;   // master write data
  logic [31:0] dat_s;   // slave read data
  logic        ack;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, stall
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Purpose : pipelined Wishbone slave in front of a 2^AWIDTH x 32 synchronous RAM with byte-lane writes.
// Latency : ack (and read data) appear exactly LATENCY cycles after the accepting edge, in order.
// Backpr. : stall = busy_i | reset; it blocks new requests only, in-flight ones keep draining.
// Ports   : clk_i clock, rst_i async active-low reset, bus (if_wb slave), busy_i external throttle.
module wb_mem_slave #(
  parameter int    AWIDTH    = 12,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic clk_i,
  input  logic rst_i,
  if_wb.slave  bus,
  input  logic busy_i
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [31:0]       mem [DEPTH];
  logic [AWIDTH-1:0] idx;
  logic              accept;
  logic [LATENCY-1:0] vld;
  logic [31:0]       rd_q [LATENCY];
  logic              unused_adr;

  // Byte offset and bits above the RAM size are dropped, so addresses wrap.
  assign idx        = bus.adr[AWIDTH+1:2];
  assign unused_adr = ^{bus.adr[31:AWIDTH+2], bus.adr[1:0]};

  // Stall never looks at ack, so a master can combinationally chain on it.
  assign bus.stall = busy_i | ~rst_i;
  assign accept    = bus.cyc & bus.stb & ~bus.stall;

  // RAM array: written on the accepting edge, never reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.sel[b]) mem[idx][8*b +: 8] <= bus.dat_m[8*b +: 8];
      end
    end
  end

  // Response pipeline: stage 0 is the synchronous RAM read register, the
  // remaining LATENCY-1 stages just carry data and valid to line up with ack.
  // Reads and writes share the valid chain, which keeps acks in order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) rd_q[i] <= '0;
    end else begin
      vld[0] <= accept;
      if (accept && !bus.we) rd_q[0] <= mem[idx];
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        rd_q[i] <= rd_q[i-1];
      end
      // Master abandoned the cycle: drop everything in flight.
      if (!bus.cyc) vld <= '0;
    end
  end

  // The cyc gate is the only combinational term on ack; it hides an ack that
  // was registered in the same cycle the master dropped cyc.
  assign bus.ack   = vld[LATENCY-1] & bus.cyc;
  assign bus.dat_s = bus.ack ? rd_q[LATENCY-1] : '0;

endmodule
